// File: rtl/fifo_flags_if.sv
// Producer/consumer bundle for fifo_flags: request/data inputs and status/data outputs.
// Handshake: wr/w_data and rd are sampled on the rising edge. A write is taken when
// wr && (!full || rd taken), and a read is taken when rd && !empty. Rejected requests
// only raise the sticky overflow/underflow flags, and all status outputs are registered.
interface fifo_flags_if #(
  parameter int B = 8,
  parameter int W = 3
);
  logic         clr;
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic [B-1:0] r_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output clr, wr, w_data, rd,
    input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr, w_data, rd,
    output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count,
// sticky error flags, a synchronous clear and a choice of FWFT or registered read data.
module fifo_flags #(
  parameter int B        = 8,
  parameter int W        = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  fifo_flags_if.slave f
);
  localparam int         DEPTH  = 2 ** W;
  localparam logic [W:0] FULL_C = {1'b1, {W{1'b0}}};
  localparam logic [W:0] AF_C   = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_C   = (W+1)'(AE_LEVEL);

  logic [B-1:0] mem_q [DEPTH];
  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         rd_ok, wr_ok;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
  assign rd_ok = f.rd && (count_q != '0);
  assign wr_ok = f.wr && ((count_q != FULL_C) || rd_ok);

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (f.clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
      if (f.wr && !wr_ok) ovf_d = 1'b1;
      if (f.rd && !rd_ok) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !f.clr) mem_q[w_ptr_q] <= f.w_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign f.r_data = mem_q[r_ptr_q];
    end else begin : g_reg
      logic [B-1:0] r_data_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)               r_data_q <= '0;
        else if (rd_ok && !f.clr) r_data_q <= mem_q[r_ptr_q];
      end
      assign f.r_data = r_data_q;
    end
  endgenerate

  assign f.count        = count_q;
  assign f.full         = (count_q == FULL_C);
  assign f.empty        = (count_q == '0);
  assign f.almost_full  = (count_q >= AF_C);
  assign f.almost_empty = (count_q <= AE_C);
  assign f.overflow     = ovf_q;
  assign f.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: one FWFT and one registered-read instance share the same stimulus
// and are checked every cycle against a reference occupancy model and a data queue.
module tb_fifo_flags;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] w_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  int         m_count = 0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] exp_q[$];

  fifo_flags_if #(.B(8), .W(3)) f1 ();
  fifo_flags_if #(.B(8), .W(3)) f0 ();

  assign f1.clr = clr;  assign f1.wr = wr;  assign f1.rd = rd;  assign f1.w_data = w_data;
  assign f0.clr = clr;  assign f0.wr = wr;  assign f0.rd = rd;  assign f0.w_data = w_data;

  fifo_flags #(.B(8), .W(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .f(f1)
  );
  fifo_flags #(.B(8), .W(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset(reset), .f(f0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string t, input logic [3:0] cnt, input logic fu, input logic em,
                            input logic af, input logic ae, input logic ov, input logic un);
    check_eq({t, ":count"}, 32'(cnt), 32'(m_count));
    check_eq({t, ":full"}, 32'(fu), 32'(m_count == 8));
    check_eq({t, ":empty"}, 32'(em), 32'(m_count == 0));
    check_eq({t, ":afull"}, 32'(af), 32'(m_count >= 6));
    check_eq({t, ":aempty"}, 32'(ae), 32'(m_count <= 2));
    check_eq({t, ":ovf"}, 32'(ov), 32'(m_ovf));
    check_eq({t, ":udf"}, 32'(un), 32'(m_udf));
  endtask

  task automatic check_all(input string t);
    check_inst({t, "/fwft"}, f1.count, f1.full, f1.empty, f1.almost_full, f1.almost_empty,
               f1.overflow, f1.underflow);
    check_inst({t, "/reg"}, f0.count, f0.full, f0.empty, f0.almost_full, f0.almost_empty,
               f0.overflow, f0.underflow);
    check_eq({t, "/reg:rdata"}, 32'(f0.r_data), 32'(m_rdata));
    if (exp_q.size() > 0) check_eq({t, "/fwft:head"}, 32'(f1.r_data), 32'(exp_q[0]));
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic do_cycle(input string t, input logic w, input logic [7:0] d,
                          input logic r, input logic c);
    logic       ra, wa;
    logic [7:0] head;
    wr = w; w_data = d; rd = r; clr = c;
    ra = r && (m_count != 0);
    wa = w && ((m_count != 8) || ra);
    #1;
    if (c) begin
      m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
      exp_q.delete();
    end else begin
      if (ra) begin
        head = exp_q.pop_front();
        check_eq({t, "/fwft:pop"}, 32'(f1.r_data), 32'(head));
        m_rdata = head;
      end
      if (wa) exp_q.push_back(d);
      if (wa && !ra) m_count++;
      if (ra && !wa) m_count--;
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_udf = 1'b1;
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    check_all(t);
  endtask

  task automatic model_reset();
    m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    // reset held 20ns
    #20 reset = 1'b0;
    @(posedge clk); #1;
    check_all("reset");

    // fill, then one write too many
    for (int i = 1; i <= 8; i++) do_cycle("fill", 1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    do_cycle("ovf", 1'b1, 8'h99, 1'b0, 1'b0);

    // drain in order, then one read too many
    for (int i = 0; i < 8; i++) do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle("udf", 1'b0, 8'h00, 1'b1, 1'b0);

    do_cycle("clr0", 1'b0, 8'h00, 1'b0, 1'b1);

    // simultaneous read/write at full and at empty
    for (int i = 0; i < 8; i++) do_cycle("fill2", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    do_cycle("full_wr_rd", 1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle("empty_wr_rd", 1'b1, 8'h5A, 1'b1, 1'b0);
    do_cycle("read_5a", 1'b0, 8'h00, 1'b1, 1'b0);

    // pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) do_cycle("wrap_w", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) do_cycle("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // random mixed traffic
    for (int i = 0; i < 40; i++)
      do_cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'b0);

    // clear with a concurrent write, starting from count=5
    do_cycle("pre_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) do_cycle("clr_fill", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    do_cycle("clr_wr", 1'b1, 8'hEE, 1'b0, 1'b1);
    do_cycle("after_clr", 1'b1, 8'h42, 1'b0, 1'b0);
    do_cycle("after_clr_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-burst, between edges
    for (int i = 0; i < 3; i++) do_cycle("burst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    do_cycle("burst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    wr = 1'b1; w_data = 8'h77;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_held");
    @(negedge clk);
    reset = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    check_all("rst_release");
    do_cycle("post_rst_w", 1'b1, 8'hC3, 1'b0, 1'b0);
    do_cycle("post_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
